// File: rtl/regfile_pkg.sv
// Shared constants for the multi-port register file: default geometry
// and the legal range of read/write port counts.
package regfile_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_SEL_BITS   = 5;
  localparam int DEF_NUM_RD     = 2;
  localparam int DEF_NUM_WR     = 1;

  localparam int MIN_NUM_RD = 1;
  localparam int MAX_NUM_RD = 4;
  localparam int MIN_NUM_WR = 1;
  localparam int MAX_NUM_WR = 2;

  function automatic bit params_ok(int data_width, int sel_bits, int num_rd, int num_wr);
    return (data_width >= 1) && (sel_bits >= 1) &&
           (num_rd >= MIN_NUM_RD) && (num_rd <= MAX_NUM_RD) &&
           (num_wr >= MIN_NUM_WR) && (num_wr <= MAX_NUM_WR);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy vector. An issue (set) beats a same-cycle write (clear)
// because the newly issued producer supersedes the one being retired.
module regfile_scoreboard #(
  parameter int SEL_BITS = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       set_en_i,
  input  logic [SEL_BITS-1:0]        set_sel_i,
  input  logic [(1<<SEL_BITS)-1:0]   clr_i,
  output logic [(1<<SEL_BITS)-1:0]   busy_o
);

  localparam int DEPTH = 1 << SEL_BITS;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  always_comb begin
    busy_d = busy_q & ~clr_i;
    if (set_en_i) busy_d[set_sel_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with issue scoreboard; register 0 is hardwired zero.
// Define REGFILE_MP_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SEL_BITS   = DEF_SEL_BITS,
  parameter int NUM_RD     = DEF_NUM_RD,
  parameter int NUM_WR     = DEF_NUM_WR
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_RD*SEL_BITS-1:0]   rd_sel,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*SEL_BITS-1:0]   wr_sel,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
  input  logic                         iss_en,
  input  logic [SEL_BITS-1:0]          iss_sel
);

  localparam int DEPTH = 1 << SEL_BITS;

  if (!params_ok(DATA_WIDTH, SEL_BITS, NUM_RD, NUM_WR)) begin : g_param_err
    $error("regfile_mp: DATA_WIDTH/SEL_BITS/NUM_RD/NUM_WR out of range");
  end

  // Low through reset and the first edge after release, so that edge commits nothing.
  logic run_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]      wr_hit;
  logic [SEL_BITS-1:0]   wsel;

  always_comb begin
    wr_hit = '0;
    wsel   = '0;
    for (int r = 0; r < DEPTH; r++) mem_d[r] = mem_q[r];
    for (int p = 0; p < NUM_WR; p++) begin
      wsel = wr_sel[p*SEL_BITS +: SEL_BITS];
      if (run_q && wr_en[p]) begin
        wr_hit[wsel] = 1'b1;
        mem_d[wsel]  = wr_data[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    wr_hit[0] = 1'b0;
    mem_d[0]  = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < DEPTH; r++) mem_q[r] <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) mem_q[r] <= mem_d[r];
    end
  end

  logic             set_en;
  logic [DEPTH-1:0] busy;

  assign set_en = run_q & iss_en;

  regfile_scoreboard #(.SEL_BITS(SEL_BITS)) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .set_en_i  (set_en),
    .set_sel_i (iss_sel),
    .clr_i     (wr_hit),
    .busy_o    (busy)
  );

  logic [SEL_BITS-1:0] rsel;

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    rsel    = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rsel = rd_sel[i*SEL_BITS +: SEL_BITS];
      rd_data[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[rsel];
      rd_busy[i] = busy[rsel];
`ifdef REGFILE_MP_BYPASS_EN
      if (wr_hit[rsel]) begin
        rd_data[i*DATA_WIDTH +: DATA_WIDTH] = mem_d[rsel];
        rd_busy[i] = set_en && (iss_sel == rsel);
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a 2-write/2-read 32-bit instance and a
// 64-bit 4-read instance; expectations follow REGFILE_MP_BYPASS_EN if defined.
module tb_regfile_mp;

`ifdef REGFILE_MP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [9:0]  rd_sel0;
  logic [63:0] rd_data0;
  logic [1:0]  rd_busy0;
  logic [1:0]  wr_en0;
  logic [9:0]  wr_sel0;
  logic [63:0] wr_data0;
  logic        iss_en0;
  logic [4:0]  iss_sel0;

  logic [15:0]  rd_sel1;
  logic [255:0] rd_data1;
  logic [3:0]   rd_busy1;
  logic [0:0]   wr_en1;
  logic [3:0]   wr_sel1;
  logic [63:0]  wr_data1;
  logic         iss_en1;
  logic [3:0]   iss_sel1;

  regfile_mp #(.DATA_WIDTH(32), .SEL_BITS(5), .NUM_RD(2), .NUM_WR(2)) u0 (
    .clk(clk), .reset(reset),
    .rd_sel(rd_sel0), .rd_data(rd_data0), .rd_busy(rd_busy0),
    .wr_en(wr_en0), .wr_sel(wr_sel0), .wr_data(wr_data0),
    .iss_en(iss_en0), .iss_sel(iss_sel0)
  );

  regfile_mp #(.DATA_WIDTH(64), .SEL_BITS(4), .NUM_RD(4), .NUM_WR(1)) u1 (
    .clk(clk), .reset(reset),
    .rd_sel(rd_sel1), .rd_data(rd_data1), .rd_busy(rd_busy1),
    .wr_en(wr_en1), .wr_sel(wr_sel1), .wr_data(wr_data1),
    .iss_en(iss_en1), .iss_sel(iss_sel1)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr0(input int p, input logic [4:0] sel, input logic [31:0] data);
    wr_en0[p] = 1'b1;
    wr_sel0[p*5 +: 5] = sel;
    wr_data0[p*32 +: 32] = data;
  endtask

  task automatic rd0(input logic [4:0] s0, input logic [4:0] s1);
    rd_sel0 = {s1, s0};
    #1;
  endtask

  initial begin
    reset = 1'b0;
    rd_sel0 = '0; wr_en0 = '0; wr_sel0 = '0; wr_data0 = '0; iss_en0 = 1'b0; iss_sel0 = '0;
    rd_sel1 = '0; wr_en1 = '0; wr_sel1 = '0; wr_data1 = '0; iss_en1 = 1'b0; iss_sel1 = '0;

    // writes and issues held during reset, and across the release edge
    wr0(0, 5'd1, 32'hDEAD);
    iss_en0 = 1'b1; iss_sel0 = 5'd2;
    rd_sel0 = {5'd2, 5'd1};
    tick(); tick();
    chk("rst_data", rd_data0, 64'h0);
    chk("rst_busy", rd_busy0, 2'b00);
    reset = 1'b1;
    tick();
    wr_en0 = '0; iss_en0 = 1'b0;
    rd0(5'd1, 5'd2);
    chk("release_wr_r1", rd_data0[31:0], 32'h0);
    chk("release_iss_r2", rd_busy0[1], 1'b0);

    // sequential writes, including a discarded write to r0
    wr0(0, 5'd1, 32'h2); tick();
    wr0(0, 5'd3, 32'h5); tick();
    wr0(0, 5'd7, 32'h9); tick();
    wr0(0, 5'd0, 32'h7); tick();
    wr_en0 = '0;
    rd0(5'd3, 5'd1);
    chk("r3", rd_data0[31:0], 32'h5);
    chk("r1", rd_data0[63:32], 32'h2);
    rd0(5'd7, 5'd0);
    chk("r7", rd_data0[31:0], 32'h9);
    chk("r0_zero", rd_data0[63:32], 32'h0);

    // same-register write on both ports: port 1 wins
    wr0(0, 5'd5, 32'hA); wr0(1, 5'd5, 32'hB);
    tick();
    wr_en0 = '0;
    rd0(5'd5, 5'd5);
    chk("r5_p0", rd_data0[31:0], 32'hB);
    chk("r5_p1", rd_data0[63:32], 32'hB);

    // scoreboard set / clear / set-wins
    iss_en0 = 1'b1; iss_sel0 = 5'd6;
    tick();
    iss_en0 = 1'b0;
    rd0(5'd6, 5'd0);
    chk("busy_r6_set", rd_busy0[0], 1'b1);
    chk("busy_r0_clear", rd_busy0[1], 1'b0);
    wr0(0, 5'd6, 32'h3);
    #1;
    chk("busy_r6_wrcycle", rd_busy0[0], (BYP ? 1'b0 : 1'b1));
    chk("data_r6_wrcycle", rd_data0[31:0], (BYP ? 32'h3 : 32'h0));
    tick();
    wr_en0 = '0;
    #1;
    chk("busy_r6_cleared", rd_busy0[0], 1'b0);
    chk("data_r6", rd_data0[31:0], 32'h3);
    iss_en0 = 1'b1; iss_sel0 = 5'd6;
    wr0(0, 5'd6, 32'h4);
    #1;
    chk("busy_r6_isswr_cycle", rd_busy0[0], (BYP ? 1'b1 : 1'b0));
    tick();
    wr_en0 = '0; iss_en0 = 1'b0;
    #1;
    chk("busy_r6_set_wins", rd_busy0[0], 1'b1);
    chk("data_r6_new", rd_data0[31:0], 32'h4);
    iss_en0 = 1'b1; iss_sel0 = 5'd6;
    tick();
    iss_sel0 = 5'd0;
    tick();
    iss_en0 = 1'b0;
    #1;
    chk("busy_r6_reissue", rd_busy0[0], 1'b1);
    chk("busy_r0_issued", rd_busy0[1], 1'b0);

    // same-cycle read of a register being written
    rd_sel0 = {5'd0, 5'd4};
    wr0(0, 5'd4, 32'hC);
    #1;
    chk("bypass_r4", rd_data0[31:0], (BYP ? 32'hC : 32'h0));
    tick();
    wr_en0 = '0;
    #1;
    chk("r4_after", rd_data0[31:0], 32'hC);

    // asynchronous reset mid-cycle wipes data and busy state
    wr0(0, 5'd1, 32'h1); wr0(1, 5'd2, 32'h2);
    tick();
    wr_en0 = '0;
    wr0(0, 5'd3, 32'h3);
    iss_en0 = 1'b1; iss_sel0 = 5'd2;
    tick();
    wr_en0 = '0; iss_en0 = 1'b0;
    rd0(5'd2, 5'd3);
    chk("pre_rst_busy_r2", rd_busy0[0], 1'b1);
    chk("pre_rst_r3", rd_data0[63:32], 32'h3);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_data", rd_data0, 64'h0);
    chk("midrst_busy", rd_busy0, 2'b00);
    rd0(5'd1, 5'd6);
    chk("midrst_r1_r6", rd_data0, 64'h0);
    chk("midrst_busy_r6", rd_busy0, 2'b00);
    tick();
    wr0(0, 5'd1, 32'h55);
    reset = 1'b1;
    tick();
    wr_en0 = '0;
    rd0(5'd1, 5'd2);
    chk("release_edge_ignored", rd_data0[31:0], 32'h0);
    wr0(0, 5'd1, 32'h66);
    tick();
    wr_en0 = '0;
    #1;
    chk("post_release_wr", rd_data0[31:0], 32'h66);

    // wide instance: all four ports read r15
    wr_en1 = 1'b1; wr_sel1 = 4'd15; wr_data1 = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    wr_en1 = 1'b0;
    rd_sel1 = {4'd15, 4'd15, 4'd15, 4'd15};
    #1;
    chk("w64_p0", rd_data1[63:0],    64'hFFFF_FFFF_FFFF_FFFF);
    chk("w64_p1", rd_data1[127:64],  64'hFFFF_FFFF_FFFF_FFFF);
    chk("w64_p2", rd_data1[191:128], 64'hFFFF_FFFF_FFFF_FFFF);
    chk("w64_p3", rd_data1[255:192], 64'hFFFF_FFFF_FFFF_FFFF);
    chk("w64_busy", rd_busy1, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
